// File: rtl/simd_adder_pipe.sv
// simd_adder_pipe: LANES independent WIDTH-bit add/subtract lanes with wrap,
// unsigned-saturate and signed-saturate modes. The block has a two-stage
// registered pipeline with valid/ready handshakes on both sides.
// Stage 1 captures the operands. Stage 2 holds the result and the raw
// carry/overflow flags.
module simd_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   a,
  input  logic [LANES*WIDTH-1:0]   b,
  input  logic                     op_sub,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   result,
  output logic [LANES-1:0]         carry,
  output logic [LANES-1:0]         ovf
);

  localparam int N = LANES * WIDTH;

  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_USAT = 2'b01;
  localparam logic [1:0] MODE_SSAT = 2'b10;

  // Stage 1 operand registers
  logic         s1_v;
  logic [N-1:0] s1_a;
  logic [N-1:0] s1_b;
  logic         s1_sub;
  logic [1:0]   s1_mode;

  // Stage 2 valid; the data registers are the output ports themselves
  logic s2_v;

  logic adv2;
  logic in_fire;
  logic s1_move;

  // Stage 2 can take a new beat when it is empty or being drained this cycle.
  assign adv2      = !s2_v || out_ready;
  // Gate with rst so a beat offered during the reset cycle is never accepted.
  assign in_ready  = (!s1_v || adv2) && !rst;
  assign in_fire   = in_valid && in_ready;
  assign s1_move   = s1_v && adv2;
  assign out_valid = s2_v;

  // Per-lane combinational arithmetic on the stage-1 contents
  logic [N-1:0]     lane_res;
  logic [LANES-1:0] lane_c;
  logic [LANES-1:0] lane_o;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] wrapped;
    logic [WIDTH-1:0] sat;

    // Subtract is a + ~b + 1, so the borrow shows up as carry == 0.
    assign op_a    = s1_a[gi*WIDTH +: WIDTH];
    assign op_b    = s1_sub ? ~s1_b[gi*WIDTH +: WIDTH] : s1_b[gi*WIDTH +: WIDTH];
    assign sum     = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, s1_sub};
    assign wrapped = sum[WIDTH-1:0];

    assign lane_c[gi] = sum[WIDTH];
    assign lane_o[gi] = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                        (sum[WIDTH-1] != op_a[WIDTH-1]);

    // Pick the lane result according to the saturation mode (mode 11 wraps)
    always_comb begin
      sat = wrapped;
      case (s1_mode)
        MODE_USAT: begin
          if (!s1_sub && lane_c[gi]) begin
            sat = {WIDTH{1'b1}};
          end else if (s1_sub && !lane_c[gi]) begin
            sat = {WIDTH{1'b0}};
          end
        end
        MODE_SSAT: begin
          // The overflow direction always follows the sign of a.
          if (lane_o[gi]) begin
            sat = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
          end
        end
        MODE_WRAP: sat = wrapped;
        default:   sat = wrapped;
      endcase
    end

    assign lane_res[gi*WIDTH +: WIDTH] = sat;
  end

  // Stage 1: capture an accepted beat, otherwise empty when the beat moves on
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_sub  <= 1'b0;
      s1_mode <= MODE_WRAP;
    end else begin
      if (in_fire) begin
        s1_v    <= 1'b1;
        s1_a    <= a;
        s1_b    <= b;
        s1_sub  <= op_sub;
        s1_mode <= mode;
      end else if (s1_move) begin
        s1_v <= 1'b0;
      end
    end
  end

  // Stage 2: register the results when advancing, and hold them while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v   <= 1'b0;
      result <= '0;
      carry  <= '0;
      ovf    <= '0;
    end else if (adv2) begin
      s2_v <= s1_v;
      if (s1_v) begin
        result <= lane_res;
        carry  <= lane_c;
        ovf    <= lane_o;
      end
    end
  end

endmodule

// File: tb/tb_simd_adder_pipe.sv
// Testbench for simd_adder_pipe. It drives directed and randomized beats and
// compares them with a lane-wise integer reference model and a scoreboard queue.
module tb_simd_adder_pipe;

  localparam int W = 8;
  localparam int L = 4;
  localparam int N = W * L;

  typedef struct packed {
    logic [N-1:0] r;
    logic [L-1:0] c;
    logic [L-1:0] o;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         op_sub;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [L-1:0] carry;
  logic [L-1:0] ovf;

  int checks   = 0;
  int failures = 0;

  simd_adder_pipe #(.WIDTH(W), .LANES(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer arithmetic per lane, with carry meaning "no borrow" for subtract
  function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                 input logic sub, input logic [1:0] md);
    exp_t e;
    int ua, ub, us, sa, sb, st;
    int half;
    int full;
    logic [W-1:0] w;
    half = 1 << (W - 1);
    full = 1 << W;
    e = '0;
    for (int i = 0; i < L; i++) begin
      ua = int'(av[i*W +: W]);
      ub = int'(bv[i*W +: W]);
      us = sub ? ua - ub : ua + ub;
      w  = us[W-1:0];
      e.c[i] = sub ? (ua >= ub) : (us >= full);
      sa = (ua >= half) ? ua - full : ua;
      sb = (ub >= half) ? ub - full : ub;
      st = sub ? sa - sb : sa + sb;
      e.o[i] = (st > half - 1) || (st < -half);
      if (md == 2'b01) begin
        if (!sub && e.c[i]) w = '1;
        else if (sub && !e.c[i]) w = '0;
      end else if (md == 2'b10) begin
        if (e.o[i]) w = (st > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
      end
      e.r[i*W +: W] = w;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat with out_ready=1. Report how many edges it took to appear, and what appeared.
  task automatic send_one(input logic [N-1:0] av, input logic [N-1:0] bv, input logic sub,
                          input logic [1:0] md, output int lat, output exp_t got);
    int wait_c;
    wait_c    = 0;
    out_ready = 1'b1;
    a = av; b = bv; op_sub = sub; mode = md; in_valid = 1'b1;
    #1;
    while (!in_ready && wait_c < 10) begin
      step();
      wait_c++;
    end
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    got.r = result;
    got.c = carry;
    got.o = ovf;
    $display("beat a=%h b=%h sub=%0d mode=%0d -> result=%h carry=%b ovf=%b lat=%0d",
             av, bv, sub, md, got.r, got.c, got.o, lat);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      op_sub = 1'($urandom);
      mode = 2'($urandom);
      step();
      checks += 3;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      if (result !== '0) begin failures++; $display("FAIL reset_result got=%h want=0", result); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks += 2;
      if (out_valid !== 1'b0 || result !== '0) begin
        failures++; $display("FAIL idle_out got valid=%b result=%h want 0/0", out_valid, result);
      end
      if (carry !== '0 || ovf !== '0) begin
        failures++; $display("FAIL idle_flags got carry=%b ovf=%b want 0/0", carry, ovf);
      end
    end
  endtask

  task automatic test_wrap_add();
    int lat; exp_t got;
    send_one(32'hFF550F01, 32'h01AA0F01, 1'b0, 2'b00, lat, got);
    checks += 4;
    if (lat !== 2) begin failures++; $display("FAIL wrap_latency got=%0d want=2", lat); end
    if (got.r !== 32'h00FF1E02) begin failures++; $display("FAIL wrap_result got=%h want=00ff1e02", got.r); end
    if (got.c !== 4'b1000) begin failures++; $display("FAIL wrap_carry got=%b want=1000", got.c); end
    if (got.o !== 4'b0000) begin failures++; $display("FAIL wrap_ovf got=%b want=0000", got.o); end
  endtask

  task automatic test_sub_usat();
    int lat; exp_t got;
    send_one(32'h00108005, 32'h01100107, 1'b1, 2'b01, lat, got);
    checks += 3;
    if (got.r !== 32'h00007F00) begin failures++; $display("FAIL usat_result got=%h want=00007f00", got.r); end
    if (got.c !== 4'b0110) begin failures++; $display("FAIL usat_carry got=%b want=0110", got.c); end
    if (got.o !== 4'b0010) begin failures++; $display("FAIL usat_ovf got=%b want=0010", got.o); end
  endtask

  task automatic test_ssat();
    int lat; exp_t got;
    send_one(32'h7F8040C0, 32'h01FF40C0, 1'b0, 2'b10, lat, got);
    checks += 2;
    if (got.r !== 32'h7F807F80) begin failures++; $display("FAIL ssat_result got=%h want=7f807f80", got.r); end
    // Lane 0 is -64 + -64 = -128, which still fits in 8 signed bits.
    if (got.o !== 4'b1110) begin failures++; $display("FAIL ssat_ovf got=%b want=1110", got.o); end
  endtask

  // kind 0: out_ready always 1; kind 1: out_ready pattern 1,0,0,1,0,1; kind 2: random traffic
  task automatic test_stream(input string name, input int nbeats, input int kind);
    exp_t q[$];
    exp_t exp_v;
    exp_t snap;
    exp_t cur;
    int occ, sent, recv, cyc;
    bit held, saw_stall, fin, fout, exp_ready;
    bit pat[6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    occ = 0; sent = 0; recv = 0; cyc = 0; held = 0; saw_stall = 0; snap = '0;
    while ((sent < nbeats || recv < nbeats) && cyc < 2000) begin
      if (kind == 0) out_ready = 1'b1;
      else if (kind == 1) out_ready = pat[cyc % 6];
      else out_ready = ($urandom_range(0, 3) != 0);
      if (sent < nbeats) in_valid = (kind == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      else in_valid = 1'b0;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      op_sub = 1'($urandom);
      mode = 2'($urandom);
      #1;
      exp_ready = !(occ == 2 && !out_ready);
      checks++;
      if (in_ready !== exp_ready) begin
        failures++; $display("FAIL %s in_ready cyc=%0d got=%b want=%b", name, cyc, in_ready, exp_ready);
      end
      if (in_ready === 1'b0) saw_stall = 1;
      cur.r = result; cur.c = carry; cur.o = ovf;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || cur !== snap) begin
          failures++; $display("FAIL %s stall_hold cyc=%0d got=%b/%h want=1/%h", name, cyc, out_valid, cur, snap);
        end
      end
      fout = out_valid && out_ready;
      fin  = in_valid && in_ready;
      if (fout) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL %s extra_beat cyc=%0d got=%h want=none", name, cyc, cur);
        end else begin
          exp_v = q.pop_front();
          if (cur !== exp_v) begin
            failures++; $display("FAIL %s beat%0d got=%h want=%h", name, recv, cur, exp_v);
          end
        end
        $display("%s beat %0d result=%h carry=%b ovf=%b", name, recv, result, carry, ovf);
        recv++;
      end
      if (fin) begin
        q.push_back(model(a, b, op_sub, mode));
        sent++;
      end
      occ = occ + int'(fin) - int'(fout);
      held = out_valid && !out_ready;
      snap = cur;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv != nbeats || q.size() != 0) begin
      failures++; $display("FAIL %s count got=%0d want=%0d", name, recv, nbeats);
    end
    if (kind == 1) begin
      checks++;
      if (!saw_stall) begin failures++; $display("FAIL %s stall_seen got=0 want=1", name); end
    end
    if (kind == 0) begin
      checks++;
      if (cyc != nbeats + 2) begin failures++; $display("FAIL %s throughput cycles got=%0d want=%0d", name, cyc, nbeats + 2); end
    end
  endtask

  task automatic test_reset_midstream();
    int sent, cyc, lat;
    exp_t got, exp_v;
    logic [N-1:0] av, bv;
    out_ready = 1'b0;
    in_valid = 1'b1;
    sent = 0; cyc = 0;
    while (sent < 2 && cyc < 10) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      #1;
      if (in_ready) sent++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    #1;
    checks += 2;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_full_valid got=%b want=1", out_valid); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_full_ready got=%b want=0", in_ready); end
    rst = 1'b1;
    in_valid = 1'b1;
    step();
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b want=0", in_ready); end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_after_rst_valid got=%b want=0", out_valid); end
    end
    av = {$urandom, $urandom};
    bv = {$urandom, $urandom};
    exp_v = model(av, bv, 1'b1, 2'b10);
    send_one(av, bv, 1'b1, 2'b10, lat, got);
    checks += 2;
    if (lat !== 2) begin failures++; $display("FAIL mid_fresh_latency got=%0d want=2", lat); end
    if (got !== exp_v) begin failures++; $display("FAIL mid_fresh_beat got=%h want=%h", got, exp_v); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op_sub = 1'b0; mode = 2'b00;
    test_reset();
    test_wrap_add();
    test_sub_usat();
    test_ssat();
    test_stream("back_to_back", 10, 0);
    test_stream("backpressure", 6, 1);
    test_stream("random", 40, 2);
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
